// File: rtl/shreg_pkg.sv
// Shared types and helpers for the serial shift-register writer.
package shreg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } shreg_state_t;

  // Width of a counter that must hold 0..max_val without wrapping.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/shreg_writer_if.sv
// Word handshake between a producer and the shift-register writer.
interface shreg_writer_if #(
  parameter int unsigned DATA_W = 24
);
  logic [DATA_W-1:0] data;
  logic              d_valid;
  logic              d_ready;

  modport master (output data, output d_valid, input d_ready);
  modport slave  (input data, input d_valid, output d_ready);
endinterface

// File: rtl/shreg_tick_gen.sv
// Bit-period enable: pulses every CLK_DIV cycles while enabled, held at zero otherwise.
module shreg_tick_gen
  import shreg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_c_o
);

  localparam int unsigned        CNT_W = cnt_width(CLK_DIV);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick_c_o = en_i && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || !en_i || tick_c_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/shreg_writer.sv
// Serialises words onto a 74HC595-style chain (sh_cp/st_cp/d) with a one-word pending buffer.
module shreg_writer
  import shreg_pkg::*;
#(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned CLK_DIV   = 1,
  parameter int unsigned STCP_W    = 1,
  parameter int unsigned LSB_FIRST = 0
) (
  input  logic           clk,
  input  logic           rst,
  shreg_writer_if.slave  bus,
  output logic           busy,
  output logic           sh_cp,
  output logic           st_cp,
  output logic           d
);

  localparam int unsigned        BIT_W    = cnt_width(DATA_W);
  localparam int unsigned        LAT_W    = cnt_width(STCP_W);
  localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [LAT_W-1:0]   LAST_LAT = LAT_W'(STCP_W - 1);

  if (DATA_W < 2) begin : g_bad_data_w
    $error("shreg_writer: DATA_W must be 2 or more");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("shreg_writer: CLK_DIV must be 1 or more");
  end
  if (STCP_W < 1) begin : g_bad_stcp_w
    $error("shreg_writer: STCP_W must be 1 or more");
  end
  if (LSB_FIRST > 1) begin : g_bad_lsb_first
    $error("shreg_writer: LSB_FIRST must be 0 or 1");
  end

  shreg_state_t      state_q;
  logic              pend_valid_q;
  logic [DATA_W-1:0] pend_data_q;
  logic [DATA_W-1:0] shreg_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [LAT_W-1:0]  lat_cnt_q;
  logic              high_q;
  logic              sh_cp_q;
  logic              st_cp_q;
  logic              busy_q;

  logic              accept_c;
  logic              tick_c;
  logic [DATA_W-1:0] load_word_c;
  logic [DATA_W-1:0] shreg_shift_c;

  // The data bus is only looked at when the buffer is empty.
  assign accept_c      = bus.d_valid & ~pend_valid_q;
  assign bus.d_ready   = ~pend_valid_q;
  assign load_word_c   = pend_valid_q ? pend_data_q : bus.data;
  assign shreg_shift_c = (LSB_FIRST != 0) ? {1'b0, shreg_q[DATA_W-1:1]}
                                          : {shreg_q[DATA_W-2:0], 1'b0};

  assign d     = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[DATA_W-1];
  assign sh_cp = sh_cp_q;
  assign st_cp = st_cp_q;
  assign busy  = busy_q;

  shreg_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .en_i     (state_q == SHIFT),
    .tick_c_o (tick_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      lat_cnt_q    <= '0;
      high_q       <= 1'b0;
      sh_cp_q      <= 1'b0;
      st_cp_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      if (accept_c && (state_q != IDLE)) begin
        pend_valid_q <= 1'b1;
        pend_data_q  <= bus.data;
      end

      case (state_q)
        IDLE: begin
          if (pend_valid_q || accept_c) begin
            state_q      <= SHIFT;
            shreg_q      <= load_word_c;
            pend_valid_q <= 1'b0;
            bit_cnt_q    <= '0;
            high_q       <= 1'b0;
            sh_cp_q      <= 1'b0;
            busy_q       <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end

        SHIFT: begin
          if (tick_c) begin
            if (!high_q) begin
              sh_cp_q <= 1'b1;
              high_q  <= 1'b1;
            end else begin
              // Falling sh_cp advances the register, so d changes only at bit boundaries.
              sh_cp_q   <= 1'b0;
              high_q    <= 1'b0;
              shreg_q   <= shreg_shift_c;
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
              if (bit_cnt_q == LAST_BIT) begin
                state_q   <= LATCH;
                st_cp_q   <= 1'b1;
                lat_cnt_q <= '0;
              end
            end
          end
        end

        LATCH: begin
          if (lat_cnt_q == LAST_LAT) begin
            st_cp_q <= 1'b0;
            if (pend_valid_q) begin
              state_q      <= SHIFT;
              shreg_q      <= pend_data_q;
              pend_valid_q <= 1'b0;
              bit_cnt_q    <= '0;
              high_q       <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= accept_c;
            end
          end else begin
            lat_cnt_q <= lat_cnt_q + LAT_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/shreg_writer.md
SHREG_WRITER -- requirements
Module: shreg_writer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 24, giving the bits per word; legal values are 2 or more.
REQ-002 The block SHALL have parameter CLK_DIV, default 1, giving the clk cycles per sh_cp half-period; legal values are 1 or more.
REQ-003 The block SHALL have parameter STCP_W, default 1, giving the st_cp pulse width in clk cycles; legal values are 1 or more.
REQ-004 The block SHALL have parameter LSB_FIRST, default 0; 0 shifts MSB first and 1 shifts LSB first.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port data, input, DATA_W bits: the word to shift out.
REQ-008 The block SHALL have port d_valid, input, 1 bit: data is valid.
REQ-009 The block SHALL have port d_ready, output, 1 bit: a word is accepted when d_valid and d_ready are both 1.
REQ-010 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE, or while a word is pending.
REQ-011 The block SHALL have ports sh_cp, st_cp and d, each an output of 1 bit: shift clock, storage-latch clock and serial data to the external register chain.

Function
REQ-012 The FSM SHALL have three states (IDLE, SHIFT, LATCH) plus a one-entry pending buffer (pend_data, pend_valid).
REQ-013 d_ready SHALL equal !pend_valid, so a word is accepted in any state while the buffer is empty.
REQ-014 In IDLE, an accepted word SHALL load the shift register directly, bypassing the buffer; SHIFT is entered on the next cycle.
REQ-015 In SHIFT or LATCH, an accepted word SHALL be stored in the buffer and pend_valid set.
REQ-016 In IDLE with pend_valid=1, the block SHALL load the shift register from the buffer, clear pend_valid and enter SHIFT on the next cycle.
REQ-017 In SHIFT, each bit SHALL drive sh_cp low for CLK_DIV cycles, then high for CLK_DIV cycles; d SHALL be stable for the whole bit period.
REQ-018 The shift register SHALL advance one bit on the cycle that sh_cp returns low; MSB-first shifts left and LSB-first shifts right, filling with 0.
REQ-019 After the DATA_W-th high phase, the FSM SHALL enter LATCH with sh_cp=0.
REQ-020 In LATCH, st_cp SHALL be 1 for exactly STCP_W cycles.
REQ-021 On leaving LATCH, the FSM SHALL go to SHIFT (loading from the buffer and clearing pend_valid) if pend_valid=1, otherwise to IDLE.
REQ-022 A word SHALL occupy exactly 2*CLK_DIV*DATA_W SHIFT cycles plus STCP_W LATCH cycles; back-to-back words SHALL have no IDLE gap.
REQ-023 A d_valid that arrives while pend_valid=1 SHALL be ignored; the data input SHALL NOT be sampled in that cycle.
REQ-024 A word accepted into an empty buffer on the final LATCH cycle SHALL follow the REQ-016 path, costing one IDLE cycle.
REQ-025 sh_cp, st_cp, d and busy SHALL be registered outputs with no combinational path from any input.
REQ-026 The bit counter SHALL be $clog2(DATA_W+1) bits wide and the divider counter SHALL be $clog2(CLK_DIV+1) bits wide; neither SHALL wrap during a word.

Reset
REQ-027 On rst=1, the block SHALL set state to IDLE, pend_valid to 0 and the shift register to 0.
REQ-028 On rst=1, sh_cp, st_cp, d and busy SHALL be 0 and d_ready SHALL be 1.
REQ-029 A reset during SHIFT or LATCH SHALL abort the word with no further sh_cp edges, no st_cp pulse and the pending word discarded.
REQ-030 After reset is released, the block SHALL accept a word on the first cycle.

Structure
REQ-031 Package shreg_pkg SHALL hold the state enum typedef shreg_state_t (IDLE, SHIFT, LATCH).
REQ-032 The bit period SHALL come from one sub-module, shreg_tick_gen, a CLK_DIV-cycle enable generator that is cleared when not in SHIFT.
REQ-033 Parameter legality (REQ-001 to REQ-004) SHALL be checked by elaboration-time assertions.

Verification
REQ-034 Basic word (defaults, data=0xA5F00F, one-cycle d_valid): 24 sh_cp rising edges with d sampled at each edge giving 0xA5F00F MSB first, then one st_cp pulse; the whole word takes 49 cycles and busy falls afterwards.
REQ-035 LSB-first (LSB_FIRST=1, DATA_W=8, CLK_DIV=3, data=0x01): the first bit is 1 and the rest are 0; sh_cp low and high phases are each 3 cycles; 8 rising edges.
REQ-036 Back-to-back: send word A, then word B during A's SHIFT; d_ready drops after B is taken, B's first sh_cp low phase starts the cycle after A's st_cp ends, and a third word offered before B starts is not accepted.
REQ-037 Reset mid-word: assert rst after the 10th rising edge; all outputs go to 0 the next cycle, no st_cp follows and d_ready returns to 1.
REQ-038 Latch width (STCP_W=4): st_cp is high for exactly 4 cycles while sh_cp stays 0, and a word accepted on the last LATCH cycle starts after one IDLE cycle.
